fetch_prefetch_queue: RTL
=========================

// Module: fetch_prefetch_queue
// PURPOSE
//  Decoupled instruction-fetch front end: sequential PC generator, in-order request/response imem port,
//  DEPTH-entry prefetch FIFO of {pc, instr} pairs with valid/ready handshake to decode.
//  Branch/jump redirect flushes the FIFO and drops stale in-flight responses.
//  Sits between instruction memory and the decoder; replaces the single-register PC fetch stage.
// PARAMETERS
//  XLEN      32  instruction/data width of imem response and out_instr
//  PCLEN     32  PC width; all PC arithmetic is modulo 2^PCLEN
//  RESET_PC  0   PC of first fetch after reset
//  DEPTH     4   FIFO entries and max (queued + outstanding) requests; power of 2, >=2
// PORTS
//  clk             in   1      clock, all state updates on posedge
//  reset           in   1      synchronous, active-high
//  redirect        in   1      taken branch/jump: restart fetch at redirect_pc
//  redirect_pc     in   PCLEN  new PC; bits [1:0] ignored (forced 0)
//  imem_req_valid  out  1      request valid
//  imem_req_ready  in   1      memory accepts request this cycle
//  imem_req_addr   out  PCLEN  word-aligned fetch address
//  imem_rsp_valid  in   1      response valid (in order, one per accepted request, no backpressure)
//  imem_rsp_data   in   XLEN   instruction word
//  out_valid       out  1      FIFO head valid
//  out_ready       in   1      decode consumes head
//  out_pc          out  PCLEN  PC of head instruction
//  out_instr       out  XLEN   head instruction
// BEHAVIOUR
//  State: fetch_pc (next request addr), rsp_pc (PC of next kept response), FIFO rd/wr ptrs + count,
//   outstanding (accepted, unanswered requests), drop_cnt (stale responses to discard). Counters $clog2(DEPTH)+1 bits.
//  Reset: fetch_pc=rsp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0 -> out_valid=0, imem_req_valid=0;
//   out_pc/out_instr=0. Reset mid-operation discards everything; memory is reset with the same signal.
//  Request: imem_req_valid = !reset & !redirect & (count + outstanding < DEPTH); imem_req_addr = fetch_pc.
//   Fire (valid & ready): fetch_pc += 4 (wraps), outstanding += 1. Credit rule guarantees FIFO never overflows.
//  Response (imem_rsp_valid): outstanding -= 1; if drop_cnt>0: discard, drop_cnt -= 1;
//   else push {rsp_pc, imem_rsp_data}, rsp_pc += 4.
//  Output: out_* driven from registered FIFO head; pop when out_valid & out_ready. Response-to-out_valid latency 1 cycle.
//   Simultaneous push and pop legal at any count, incl. full; count unchanged.
//  Redirect (highest priority, any cycle): no request fires; FIFO flushed (pop/push this cycle ignored);
//   drop_cnt <= outstanding - imem_rsp_valid (all remaining in-flight are stale);
//   fetch_pc = rsp_pc = {redirect_pc[PCLEN-1:2],2'b00}; first new request offered next cycle.
//   out_valid=0 from the cycle after redirect until first kept response lands (>=2 cycles).
//  Redirect with drop_cnt already >0: overwritten by new value above (old stale ones are included in outstanding).
//  Back-to-back redirects: last one wins; no request issued between them.
//  PC wrap: 2^PCLEN-4 + 4 -> 0, no error.
//  Invariant (assert in sim): count + outstanding <= DEPTH; drop_cnt <= outstanding; no rsp when outstanding==0.
// TESTING
//  1 Reset, mem 1-cycle latency always ready, out_ready=1 -> addr 0,4,8,...; out_pc 0,4,8 in order, one per cycle after fill.
//  2 out_ready=0, DEPTH=4 -> exactly 4 requests issued then imem_req_valid=0; release -> 4 instrs out, fetch resumes at 0x10.
//  3 Mem latency 3, 3 outstanding, redirect to 0x200 -> 3 responses dropped, next out_pc=0x200, no stale PC ever at output.
//  4 Redirect in same cycle as a response and a pop -> FIFO empty next cycle, drop_cnt=outstanding-1, no request that cycle.
//  5 RESET_PC=0xFFFFFFF8, PCLEN=32 -> out_pc FFFFFFF8, FFFFFFFC, 00000000; redirect_pc=0x103 -> fetch at 0x100.
//  6 Reset asserted with 2 outstanding and 3 queued -> next cycle out_valid=0, imem_req_valid=0; after release fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//   Decoupled instruction-fetch front end. A sequential PC generator issues
//   word-aligned requests to an in-order instruction memory. Kept responses
//   are paired with their PC and queued in a DEPTH-entry FIFO that feeds
//   decode over a valid/ready handshake. A redirect flushes the FIFO and
//   discards every response that is still in flight at that moment.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. Valid never depends on ready in the same cycle. The imem
//   response channel has no ready: one response per accepted request, in
//   order.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   redirect         restart fetch at redirect_pc (highest priority)
//   redirect_pc      new fetch PC, bits [1:0] ignored
//   imem_req_valid   request offered, address imem_req_addr
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    word-aligned fetch address
//   imem_rsp_valid   response word present on imem_rsp_data
//   imem_rsp_data    instruction word
//   out_valid        FIFO head valid
//   out_ready        decode consumes the head
//   out_pc           PC of the head instruction (0 when empty)
//   out_instr        head instruction (0 when empty)

module fetch_prefetch_queue #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      PCLEN    = 32,
    parameter logic [PCLEN-1:0] RESET_PC = '0,
    parameter int unsigned      DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [PCLEN-1:0] redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [PCLEN-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [XLEN-1:0]  imem_rsp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PCLEN-1:0] out_pc,
    output logic [XLEN-1:0]  out_instr
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [PCLEN-1:0] PC_STEP = PCLEN'(4);

    logic [PCLEN-1:0] fetch_pc;
    logic [PCLEN-1:0] rsp_pc;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    drop_cnt;

    logic [PCLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0]  instr_mem [DEPTH];

    logic [PCLEN-1:0] redirect_aligned;
    logic             redirect_pc_unused;
    logic [CW:0]      credit_used;
    logic             req_fire;
    logic             rsp_drop;
    logic             push;
    logic             pop;

    assign redirect_aligned   = {redirect_pc[PCLEN-1:2], 2'b00};
    assign redirect_pc_unused = ^redirect_pc[1:0];

    // Queued entries plus in-flight requests (stale ones included) may never
    // exceed DEPTH, so every response that is kept always has a FIFO slot.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && !redirect && (credit_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop  = imem_rsp_valid && (drop_cnt != '0);
    assign push      = imem_rsp_valid && !rsp_drop && !redirect;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redirect;

    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            // req_fire is already low during a redirect.
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect) begin
                // Everything still in flight after this cycle belongs to the
                // abandoned path; any older drop count is a subset of it.
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    rsp_pc <= rsp_pc + PC_STEP;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: out_valid gates the head.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem[wr_ptr]    <= rsp_pc;
            instr_mem[wr_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (credit_used <= DEPTH_W)
                else $error("fetch_prefetch_queue: count + outstanding exceeds DEPTH");
            assert (drop_cnt <= outstanding)
                else $error("fetch_prefetch_queue: drop_cnt exceeds outstanding");
            assert (!(imem_rsp_valid && (outstanding == '0)))
                else $error("fetch_prefetch_queue: response with nothing outstanding");
        end
    end

endmodule
